// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned 16-bit multiply/divide.
// Takes 16 RUN cycles per operation and ends with a one-cycle register-file write.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  dst,
    output logic        busy,
    output logic        wr,
    output logic [3:0]  rw,
    output logic [15:0] val
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    localparam logic [1:0] MULLO = 2'b00;
    localparam logic [1:0] MULHI = 2'b01;
    localparam logic [1:0] DIVQ  = 2'b10;
    localparam logic [1:0] DIVR  = 2'b11;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  op_q;
    logic [15:0] b_q;
    logic [3:0]  dst_q;
    logic [31:0] prod;
    logic [16:0] rem;
    logic [15:0] quo;

    logic [16:0] msum;
    logic [31:0] prod_n;
    logic [17:0] shl;
    logic [17:0] diff;
    logic [16:0] rem_n;
    logic [15:0] quo_n;
    logic [15:0] res;

    // One multiply step and one divide step, plus the result
    // selection used on the last iteration.
    always_comb begin
        msum   = {1'b0, prod[31:16]} + (prod[0] ? {1'b0, b_q} : 17'd0);
        prod_n = {msum, prod[15:1]};
        shl    = {rem, quo[15]};
        diff   = shl - {2'b00, b_q};
        rem_n  = shl[16:0];
        quo_n  = {quo[14:0], 1'b0};
        if (!diff[17]) begin
            rem_n = diff[16:0];
            quo_n = {quo[14:0], 1'b1};
        end
        res = 16'h0000;
        unique case (op_q)
            MULLO: res = prod_n[15:0];
            MULHI: res = prod_n[31:16];
            DIVQ:  res = quo_n;
            DIVR:  res = rem_n[15:0];
            default: res = 16'h0000;
        endcase
    end

    // Control FSM with the datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            wr    <= 1'b0;
            rw    <= 4'd0;
            val   <= 16'h0000;
            op_q  <= 2'b00;
            b_q   <= 16'h0000;
            dst_q <= 4'd0;
            prod  <= 32'h0;
            rem   <= 17'h0;
            quo   <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    wr <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        b_q   <= b;
                        dst_q <= dst;
                        prod  <= {16'h0000, a};
                        quo   <= a;
                        rem   <= 17'h0;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    prod <= prod_n;
                    rem  <= rem_n;
                    quo  <= quo_n;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        wr    <= 1'b1;
                        rw    <= dst_q;
                        val   <= res;
                        state <= WB;
                    end
                end
                WB: begin
                    wr    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wr    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: bench for muldiv_unit.
// Uses directed vectors, random vectors checked against an arithmetic model, and corner sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dst;
    logic        busy;
    logic        wr;
    logic [3:0]  rw;
    logic [15:0] val;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .dst   (dst),
        .busy  (busy),
        .wr    (wr),
        .rw    (rw),
        .val   (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wr) wr_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dst;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] model(input logic [1:0] o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0000, x} * {16'h0000, y};
        case (o)
            2'b00: return p[15:0];
            2'b01: return p[31:16];
            2'b10: return (y == 0) ? 16'hFFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        while (!wr && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [3:0] d,
                          input logic [15:0] e, input string nm);
        int n;
        int w0;
        @(negedge clk);
        op = o; a = x; b = y; dst = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        w0 = wr_cnt;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        wait_wr(n);
        chk({nm, " latency"}, n, 16);
        chk({nm, " rw"}, 32'(rw), 32'(d));
        chk({nm, " val"}, 32'(val), 32'(e));
        @(posedge clk);
        #1;
        chk({nm, " idle"}, {30'd0, busy, wr}, 32'd0);
        chk({nm, " pulses"}, wr_cnt - w0, 1);
    endtask

    vec_t tbl[8];

    initial begin
        int n;
        int w0;
        vec_t v;
        tbl[0] = '{2'b00, 16'h1234, 16'h5678, 4'd3, 16'h0060};
        tbl[1] = '{2'b01, 16'h1234, 16'h5678, 4'd3, 16'h0626};
        tbl[2] = '{2'b01, 16'hFFFF, 16'hFFFF, 4'd1, 16'hFFFE};
        tbl[3] = '{2'b00, 16'hFFFF, 16'hFFFF, 4'd2, 16'h0001};
        tbl[4] = '{2'b10, 16'd1000, 16'd7,    4'd4, 16'h008E};
        tbl[5] = '{2'b11, 16'd1000, 16'd7,    4'd5, 16'h0006};
        tbl[6] = '{2'b10, 16'h1234, 16'h0000, 4'd6, 16'hFFFF};
        tbl[7] = '{2'b11, 16'h1234, 16'h0000, 4'd15, 16'h1234};

        rst = 1'b1; start = 1'b0; op = 2'b00;
        a = 16'h0; b = 16'h0; dst = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", {11'd0, busy, wr, rw, val}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dst,
                   tbl[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            v.op  = 2'($urandom_range(0, 3));
            v.a   = 16'($urandom);
            v.b   = (i % 6 == 5) ? 16'h0 : 16'($urandom);
            v.dst = 4'($urandom);
            run_op(v.op, v.a, v.b, v.dst, model(v.op, v.a, v.b),
                   $sformatf("rnd%0d", i));
        end

        // start held high and operands churning during RUN
        @(negedge clk);
        op = 2'b10; a = 16'd1000; b = 16'd7; dst = 4'd5; start = 1'b1;
        @(posedge clk);
        #1;
        w0 = wr_cnt;
        n = 0;
        while (!wr && n < 40) begin
            @(negedge clk);
            op = 2'($urandom); a = 16'($urandom);
            b = 16'($urandom); dst = 4'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold latency", n, 16);
        chk("hold val", 32'(val), 32'h008E);
        chk("hold rw", 32'(rw), 32'd5);
        op = 2'b11; a = 16'd100; b = 16'd9; dst = 4'd9;
        @(posedge clk);
        #1;
        chk("hold busy E17", 32'(busy), 32'd0);
        chk("hold pulses", wr_cnt - w0, 1);
        @(posedge clk);
        #1;
        chk("b2b busy E18", 32'(busy), 32'd1);
        start = 1'b0;
        wait_wr(n);
        chk("b2b latency", n, 16);
        chk("b2b val", 32'(val), 32'd1);
        chk("b2b rw", 32'(rw), 32'd9);

        // reset in the middle of RUN
        @(negedge clk);
        op = 2'b00; a = 16'h1234; b = 16'h5678; dst = 4'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        w0 = wr_cnt;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort outs", {11'd0, busy, wr, rw, val}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort no wr", wr_cnt - w0, 0);
        chk("abort idle", 32'(busy), 32'd0);
        run_op(2'b01, 16'h1234, 16'h5678, 4'd7, 16'h0626, "after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
